// File: rtl/mips_pkg.sv
// Shared widths, defaults and bundle types for the register-file writeback path.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int DEFAULT_FIFO_DEPTH = 2;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

    function automatic reg_mask_t reg_onehot(input reg_addr_t a);
        reg_mask_t v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// ALU result, load return and register-file write bundle.
// Slave is the writeback block; master is whoever feeds and observes it.
interface regfile_writeback_if;
    import mips_pkg::*;

    logic AluValid;
    reg_addr_t AluAddr;
    reg_data_t AluData;
    logic LoadValid;
    reg_addr_t LoadAddr;
    reg_data_t LoadData;
    logic LoadReady;
    logic RegWrite;
    reg_addr_t WriteAddr;
    reg_data_t WriteData;
    logic StallReq;
    reg_mask_t Pending;

    modport slave (
        input AluValid, AluAddr, AluData,
        input LoadValid, LoadAddr, LoadData,
        output LoadReady, RegWrite, WriteAddr,
        output WriteData, StallReq, Pending
    );

    modport master (
        output AluValid, AluAddr, AluData,
        output LoadValid, LoadAddr, LoadData,
        input LoadReady, RegWrite, WriteAddr,
        input WriteData, StallReq, Pending
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order load-return buffer; exposes per-entry valid and address
// so the parent can build the pending-register mask.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic      [DEPTH-1:0]       entry_valid,
    output reg_addr_t [DEPTH-1:0]       entry_addr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic push_ok;
    logic pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok = pop && !empty;
    assign head = mem[rd_ptr];

    always_comb begin
        entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            entry_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // push and pop never share a slot: that needs full or empty
            if (pop_ok) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates ALU results against buffered load returns for the single
// register-file write port, stalling the ALU when loads starve.
module regfile_writeback
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input logic                Clock,
    input logic                Reset,
    regfile_writeback_if.slave bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic alu_ok;
    logic alu_win;
    wb_entry_t head;
    wb_entry_t load_entry;
    logic [FIFO_DEPTH-1:0] ev;
    reg_addr_t [FIFO_DEPTH-1:0] ea;
    logic [SW-1:0] starve;
    logic stall_q;
    logic reg_write;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    reg_mask_t pend;

    assign load_entry = '{addr: bus.LoadAddr, data: bus.LoadData};
    // address-0 loads complete the handshake but are dropped here
    assign push = bus.LoadValid && !full && (bus.LoadAddr != '0);
    assign alu_ok = bus.AluValid && (bus.AluAddr != '0);
    assign alu_win = alu_ok && !stall_q;
    assign pop = !empty && !alu_win;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push       (push),
        .push_entry (load_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .entry_valid(ev),
        .entry_addr (ea)
    );

    always_comb begin
        pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ev[i]) begin
                pend = pend | reg_onehot(ea[i]);
            end
        end
        pend[0] = 1'b0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            reg_write <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            starve <= '0;
            stall_q <= 1'b0;
        end else begin
            unique case (1'b1)
                alu_win: begin
                    reg_write <= 1'b1;
                    wr_addr <= bus.AluAddr;
                    wr_data <= bus.AluData;
                end
                pop: begin
                    reg_write <= 1'b1;
                    wr_addr <= head.addr;
                    wr_data <= head.data;
                end
                default: reg_write <= 1'b0;
            endcase
            if (empty || pop) begin
                starve <= '0;
            end else if (starve != SW'(STARVE_LIMIT)) begin
                starve <= starve + SW'(1);
            end
            // the loss that brings the count to the limit raises the stall
            if (pop) begin
                stall_q <= 1'b0;
            end else if (!empty && starve == SW'(STARVE_LIMIT - 1)) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign bus.LoadReady = !full;
    assign bus.RegWrite = reg_write;
    assign bus.WriteAddr = wr_addr;
    assign bus.WriteData = wr_data;
    assign bus.StallReq = stall_q;
    assign bus.Pending = pend;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed-vector bench for regfile_writeback: each task drives one
// scenario and compares outputs against hand-computed values.
module tb_regfile_writeback;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int checks = 0;
    int errors = 0;

    regfile_writeback_if bus();

    regfile_writeback #(
        .FIFO_DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.AluValid = 1'b0;
        bus.AluAddr = '0;
        bus.AluData = '0;
        bus.LoadValid = 1'b0;
        bus.LoadAddr = '0;
        bus.LoadData = '0;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        bus.AluValid = 1'b1;
        bus.AluAddr = a;
        bus.AluData = d;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        bus.LoadValid = 1'b1;
        bus.LoadAddr = a;
        bus.LoadData = d;
    endtask

    task automatic test_reset();
        idle();
        #2;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteAddr !== 5'd0 ||
            bus.WriteData !== 32'd0 || bus.StallReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs we=%b a=%0d d=%h st=%b exp all 0",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.StallReq);
        end
        checks++;
        if (bus.Pending !== 32'd0 || bus.LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_buf pend=%h rdy=%b exp 0/1",
                     bus.Pending, bus.LoadReady);
        end
        #1 Reset = 1'b1;
        step();
        checks++;
        if (bus.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle we=%b exp 0", bus.RegWrite);
        end
    endtask

    task automatic test_alu();
        alu(5'd5, 32'h1234);
        step();
        idle();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'd5 ||
            bus.WriteData !== 32'h1234) begin
            errors++;
            $display("FAIL alu_write we=%b a=%0d d=%h exp 1/5/1234",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData);
        end
        step();
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteAddr !== 5'd5 ||
            bus.WriteData !== 32'h1234) begin
            errors++;
            $display("FAIL alu_idle_hold we=%b a=%0d d=%h exp 0/5/1234",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData);
        end
    endtask

    task automatic test_load();
        load(5'd7, 32'hCAFE);
        checks++;
        if (bus.LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL load_ready rdy=%b exp 1", bus.LoadReady);
        end
        step();
        idle();
        checks++;
        if (bus.Pending !== 32'h80 || bus.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL load_enq pend=%h we=%b exp 80/0",
                     bus.Pending, bus.RegWrite);
        end
        step();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'd7 ||
            bus.WriteData !== 32'hCAFE || bus.Pending !== 32'd0) begin
            errors++;
            $display("FAIL load_write we=%b a=%0d d=%h pend=%h exp 1/7/cafe/0",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.Pending);
        end
        step();
        checks++;
        if (bus.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL load_after we=%b exp 0", bus.RegWrite);
        end
    endtask

    task automatic test_zero_addr();
        alu(5'd0, 32'hDEAD);
        load(5'd0, 32'hBEEF);
        step();
        idle();
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.Pending !== 32'd0) begin
            errors++;
            $display("FAIL zero_drop we=%b pend=%h exp 0/0",
                     bus.RegWrite, bus.Pending);
        end
        load(5'd9, 32'h99);
        step();
        idle();
        alu(5'd0, 32'h5555);
        checks++;
        if (bus.Pending !== 32'h200) begin
            errors++;
            $display("FAIL zero_pend9 pend=%h exp 200", bus.Pending);
        end
        step();
        idle();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'd9 ||
            bus.WriteData !== 32'h99 || bus.Pending !== 32'd0) begin
            errors++;
            $display("FAIL zero_r9 we=%b a=%0d d=%h pend=%h exp 1/9/99/0",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.Pending);
        end
    endtask

    task automatic test_back_to_back();
        load(5'd20, 32'h20);
        alu(5'd1, 32'h1);
        step();
        idle();
        load(5'd21, 32'h21);
        step();
        load(5'd22, 32'h22);
        checks++;
        if (bus.WriteAddr !== 5'd20 || bus.WriteData !== 32'h20 ||
            bus.Pending !== 32'h0020_0000 || bus.LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first a=%0d d=%h pend=%h rdy=%b exp 20/20/200000/1",
                     bus.WriteAddr, bus.WriteData, bus.Pending, bus.LoadReady);
        end
        step();
        idle();
        checks++;
        if (bus.WriteAddr !== 5'd21 || bus.WriteData !== 32'h21 ||
            bus.Pending !== 32'h0040_0000) begin
            errors++;
            $display("FAIL b2b_second a=%0d d=%h pend=%h exp 21/21/400000",
                     bus.WriteAddr, bus.WriteData, bus.Pending);
        end
        step();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'd22 ||
            bus.Pending !== 32'd0) begin
            errors++;
            $display("FAIL b2b_third we=%b a=%0d pend=%h exp 1/22/0",
                     bus.RegWrite, bus.WriteAddr, bus.Pending);
        end
        step();
    endtask

    task automatic test_starve();
        load(5'd3, 32'h33);
        alu(5'd10, 32'hA0);
        step();
        load(5'd4, 32'h44);
        alu(5'd11, 32'hA1);
        step();
        load(5'd5, 32'h55);
        alu(5'd12, 32'hA2);
        checks++;
        if (bus.LoadReady !== 1'b0 || bus.Pending !== 32'h18) begin
            errors++;
            $display("FAIL starve_full rdy=%b pend=%h exp 0/18",
                     bus.LoadReady, bus.Pending);
        end
        step();
        idle();
        alu(5'd13, 32'hA3);
        step();
        alu(5'd14, 32'hA4);
        checks++;
        if (bus.StallReq !== 1'b0 || bus.WriteAddr !== 5'd13) begin
            errors++;
            $display("FAIL starve_3loss st=%b a=%0d exp 0/13",
                     bus.StallReq, bus.WriteAddr);
        end
        step();
        alu(5'd15, 32'hA5);
        checks++;
        if (bus.StallReq !== 1'b1 || bus.WriteAddr !== 5'd14) begin
            errors++;
            $display("FAIL starve_stall st=%b a=%0d exp 1/14",
                     bus.StallReq, bus.WriteAddr);
        end
        step();
        idle();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteAddr !== 5'd3 ||
            bus.WriteData !== 32'h33 || bus.StallReq !== 1'b0 ||
            bus.Pending !== 32'h10) begin
            errors++;
            $display("FAIL starve_pop we=%b a=%0d d=%h st=%b pend=%h exp 1/3/33/0/10",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData,
                     bus.StallReq, bus.Pending);
        end
        step();
        checks++;
        if (bus.WriteAddr !== 5'd4 || bus.WriteData !== 32'h44 ||
            bus.Pending !== 32'd0) begin
            errors++;
            $display("FAIL starve_drain a=%0d d=%h pend=%h exp 4/44/0",
                     bus.WriteAddr, bus.WriteData, bus.Pending);
        end
        step();
    endtask

    task automatic test_async_reset();
        load(5'd6, 32'h66);
        alu(5'd1, 32'h11);
        step();
        load(5'd8, 32'h88);
        alu(5'd2, 32'h22);
        step();
        idle();
        #3 Reset = 1'b0;
        #1;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteAddr !== 5'd0 ||
            bus.WriteData !== 32'd0 || bus.StallReq !== 1'b0) begin
            errors++;
            $display("FAIL async_outs we=%b a=%0d d=%h st=%b exp all 0",
                     bus.RegWrite, bus.WriteAddr, bus.WriteData, bus.StallReq);
        end
        checks++;
        if (bus.Pending !== 32'd0 || bus.LoadReady !== 1'b1) begin
            errors++;
            $display("FAIL async_buf pend=%h rdy=%b exp 0/1",
                     bus.Pending, bus.LoadReady);
        end
        step();
        #2 Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.RegWrite !== 1'b0 || bus.Pending !== 32'd0) begin
                errors++;
                $display("FAIL async_release%0d we=%b pend=%h exp 0/0",
                         i, bus.RegWrite, bus.Pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_zero_addr();
        test_back_to_back();
        test_starve();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
